load_unit32: RTL and testbench

Multi-cycle load unit that produces the mem_data operand consumed by the decode/register-file stage on register writeback. It accepts a load request from the control unit with the ALU-computed address and runs a req/ack handshake to data RAM or the I/O port. It extracts and extends the addressed byte, halfword or word, then presents the result to writeback and stalls the pipeline until the data is valid.

---
 rtl/load_unit32.sv | 134 +++++++++++++
 tb/tb_load_unit32.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit32.sv
// Multi-cycle load unit: decodes the load type, runs a req/ack read to data RAM or I/O,
// and extracts and extends the addressed byte, halfword or word for register writeback.
module load_unit32 #(
  parameter int unsigned TIMEOUT    = 16,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic [5:0]  opcode,
  input  logic [31:0] ALU_result,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] mem_data,
  output logic        load_stall,
  output logic        load_done,
  output logic        addr_err
);

  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [5:0]       op_q;
  logic [1:0]       off_q;
  logic             req_bad;
  logic [1:0]       byte_sel;
  logic             half_sel;
  logic [7:0]       byte_val;
  logic [15:0]      half_val;
  logic [31:0]      load_val;

  // Illegal opcode or misaligned address for the requested access size
  always_comb begin
    req_bad = 1'b0;
    case (opcode)
      OP_LB, OP_LBU: req_bad = 1'b0;
      OP_LH, OP_LHU: req_bad = ALU_result[0];
      OP_LW:         req_bad = |ALU_result[1:0];
      default:       req_bad = 1'b1;
    endcase
  end

  // Lane selection and sign/zero extension of the returned word
  always_comb begin
    byte_sel = BIG_ENDIAN ? (2'd3 - off_q) : off_q;
    half_sel = BIG_ENDIAN ? ~off_q[1] : off_q[1];
    byte_val = mem_rdata[7:0];
    case (byte_sel)
      2'd0:    byte_val = mem_rdata[7:0];
      2'd1:    byte_val = mem_rdata[15:8];
      2'd2:    byte_val = mem_rdata[23:16];
      default: byte_val = mem_rdata[31:24];
    endcase
    half_val = half_sel ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   load_val = {{24{byte_val[7]}}, byte_val};
      OP_LBU:  load_val = {24'd0, byte_val};
      OP_LH:   load_val = {{16{half_val[15]}}, half_val};
      OP_LHU:  load_val = {16'd0, half_val};
      default: load_val = mem_rdata;
    endcase
  end

  // Next state, wait counter and combinational stall
  always_comb begin
    state_n    = state;
    cnt_n      = '0;
    load_stall = 1'b0;
    case (state)
      IDLE: begin
        load_stall = MemRead;
        if (MemRead) state_n = req_bad ? ERR : REQ;
      end
      REQ: begin
        load_stall = 1'b1;
        if (mem_ack)               state_n = DONE;
        else if (cnt == CNT_LAST)  state_n = ERR;
        else                       cnt_n   = cnt + CNT_W'(1);
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Registered handshake/status outputs track the state being entered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      load_done <= 1'b0;
      addr_err  <= 1'b0;
      op_q      <= '0;
      off_q     <= '0;
    end else begin
      mem_req   <= (state_n == REQ);
      load_done <= (state_n == DONE);
      addr_err  <= (state_n == ERR);
      if (state == IDLE && state_n == REQ) begin
        op_q     <= opcode;
        off_q    <= ALU_result[1:0];
        mem_addr <= {ALU_result[31:2], 2'b00};
      end
      if (state_n == DONE)     mem_data <= load_val;
      else if (state_n == ERR) mem_data <= '0;
    end
  end

endmodule

// File: tb/tb_load_unit32.sv
// Randomized and directed bench for load_unit32 against a transaction-level reference model;
// two instances (little- and big-endian lanes) share the same stimulus.
module tb_load_unit32;

  localparam int TO = 4;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  logic        clock;
  logic        reset;
  logic        MemRead;
  logic [5:0]  opcode;
  logic [31:0] ALU_result;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        mem_req, load_stall, load_done, addr_err;
  logic [31:0] mem_addr, mem_data;
  logic        req_b, stall_b, done_b, err_b;
  logic [31:0] addr_b, data_b;

  int          n_checks;
  int          n_err;
  logic [31:0] exp_addr;
  logic [31:0] exp_d0;
  logic [31:0] exp_d1;

  load_unit32 #(.TIMEOUT(TO), .BIG_ENDIAN(1'b0)) dut (
    .clock(clock), .reset(reset), .MemRead(MemRead), .opcode(opcode), .ALU_result(ALU_result),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_data(mem_data), .load_stall(load_stall), .load_done(load_done), .addr_err(addr_err)
  );

  load_unit32 #(.TIMEOUT(TO), .BIG_ENDIAN(1'b1)) dut_be (
    .clock(clock), .reset(reset), .MemRead(MemRead), .opcode(opcode), .ALU_result(ALU_result),
    .mem_req(req_b), .mem_addr(addr_b), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_data(data_b), .load_stall(stall_b), .load_done(done_b), .addr_err(err_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected writeback value: pick the addressed lane, then extend
  function automatic logic [31:0] ref_data(input logic [5:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata, input bit be);
    int         bidx;
    int         hidx;
    logic [7:0]  bv;
    logic [15:0] hv;
    bidx = be ? 3 - int'(addr[1:0]) : int'(addr[1:0]);
    hidx = be ? 1 - int'(addr[1]) : int'(addr[1]);
    bv   = 8'(rdata >> (8 * bidx));
    hv   = 16'(rdata >> (16 * hidx));
    case (op)
      OP_LB:   return bv[7] ? 32'(bv) - 32'd256 : 32'(bv);
      OP_LBU:  return 32'(bv);
      OP_LH:   return hv[15] ? 32'(hv) - 32'h10000 : 32'(hv);
      OP_LHU:  return 32'(hv);
      default: return rdata;
    endcase
  endfunction

  // One load instruction from IDLE; ack_cyc is the REQ cycle index carrying the ack
  task automatic run_load(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                          input int ack_cyc, input bit hold);
    bit legal, early, done_exp;
    bit got_done, got_err, got_done_b, got_err_b;
    int n, lat;
    legal    = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
    early    = !legal || (((op == OP_LH) || (op == OP_LHU)) && addr[0]) ||
               ((op == OP_LW) && (addr[1:0] != 2'b00));
    done_exp = !early && (ack_cyc < TO);
    MemRead = 1'b1; opcode = op; ALU_result = addr; mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    check("stall_idle", 32'(load_stall), 32'd1);
    check("req_idle", 32'(mem_req), 32'd0);
    n = 0; lat = 0; got_done = 0; got_err = 0; got_done_b = 0; got_err_b = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      if (load_done || addr_err) begin
        lat = c; got_done = load_done; got_err = addr_err; got_done_b = done_b; got_err_b = err_b;
        break;
      end
      if (mem_req) begin
        check("stall_req", 32'(load_stall), 32'd1);
        mem_ack   = (n == ack_cyc);
        mem_rdata = (n == ack_cyc) ? rdata : $urandom;
        n++;
      end else begin
        mem_ack = 1'b0;
      end
    end
    if (!early) exp_addr = {addr[31:2], 2'b00};
    exp_d0 = done_exp ? ref_data(op, addr, rdata, 1'b0) : 32'd0;
    exp_d1 = done_exp ? ref_data(op, addr, rdata, 1'b1) : 32'd0;
    check("done", 32'(got_done), 32'(done_exp));
    check("err", 32'(got_err), 32'(!done_exp));
    check("done_be", 32'(got_done_b), 32'(done_exp));
    check("err_be", 32'(got_err_b), 32'(!done_exp));
    check("latency", 32'(lat), early ? 32'd1 : (done_exp ? 32'(ack_cyc + 2) : 32'(TO + 1)));
    check("req_cycles", 32'(n), early ? 32'd0 : (done_exp ? 32'(ack_cyc + 1) : 32'(TO)));
    check("stall_end", 32'(load_stall), 32'd0);
    check("req_end", 32'(mem_req), 32'd0);
    check("mem_addr", mem_addr, exp_addr);
    check("mem_data", mem_data, exp_d0);
    check("mem_data_be", data_b, exp_d1);
    // Stray ack during DONE/ERR; MemRead still belongs to this instruction
    MemRead = hold; mem_ack = 1'b1; mem_rdata = $urandom;
    @(posedge clock); #1;
    check("idle_done", 32'(load_done), 32'd0);
    check("idle_err", 32'(addr_err), 32'd0);
    check("idle_req", 32'(mem_req), 32'd0);
    check("hold_data", mem_data, exp_d0);
    if (!hold) begin
      check("idle_stall", 32'(load_stall), 32'd0);
      mem_rdata = $urandom;
      @(posedge clock); #1;
      check("stray_req", 32'(mem_req), 32'd0);
      check("stray_done", 32'(load_done), 32'd0);
      check("stray_data", mem_data, exp_d0);
      check("stray_data_be", data_b, exp_d1);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]  r_op;
    logic [31:0] r_addr;
    int          pick;
    n_checks = 0; n_err = 0; exp_addr = '0; exp_d0 = '0; exp_d1 = '0;
    reset = 1'b1; MemRead = 1'b0; opcode = '0; ALU_result = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_data", mem_data, 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(addr_err), 32'd0);
    check("rst_stall", 32'(load_stall), 32'd0);
    reset = 1'b0;

    // Reset while a request is outstanding, then a late ack
    MemRead = 1'b1; opcode = OP_LW; ALU_result = 32'h0000_2000;
    @(posedge clock); #1;
    check("midreq_req", 32'(mem_req), 32'd1);
    reset = 1'b1; MemRead = 1'b0;
    #1;
    check("midreq_rst_req", 32'(mem_req), 32'd0);
    check("midreq_rst_addr", mem_addr, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    check("late_ack_done", 32'(load_done), 32'd0);
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_data", mem_data, 32'd0);
    @(posedge clock); #1;
    check("late_ack_done2", 32'(load_done), 32'd0);

    run_load(OP_LW, 32'h0000_1004, 32'hDEAD_BEEF, 0, 1'b0);
    check("lw_addr", mem_addr, 32'h0000_1004);
    check("lw_data", mem_data, 32'hDEAD_BEEF);

    run_load(OP_LB,  32'h0000_1003, 32'h80FF_7F01, 0, 1'b0);
    check("lb_off3", mem_data, 32'hFFFF_FF80);
    run_load(OP_LBU, 32'h0000_1003, 32'h80FF_7F01, 1, 1'b0);
    check("lbu_off3", mem_data, 32'h0000_0080);
    run_load(OP_LH,  32'h0000_1000, 32'h80FF_7F01, 2, 1'b0);
    check("lh_off0", mem_data, 32'h0000_7F01);
    run_load(OP_LH,  32'h0000_1002, 32'h80FF_7F01, 0, 1'b0);
    check("lh_off2", mem_data, 32'hFFFF_80FF);
    run_load(OP_LHU, 32'h0000_1002, 32'h80FF_7F01, 3, 1'b0);
    check("lhu_off2", mem_data, 32'h0000_80FF);

    run_load(OP_LW, 32'h0000_1002, 32'h1111_1111, 0, 1'b0);
    check("lw_mis_data", mem_data, 32'd0);
    run_load(OP_LH, 32'h0000_1001, 32'h2222_2222, 0, 1'b0);
    run_load(6'b101011, 32'h0000_1000, 32'h3333_3333, 0, 1'b0);

    run_load(OP_LW, 32'h0000_3000, 32'hCAFE_F00D, 9, 1'b0);
    check("timeout_data", mem_data, 32'd0);
    run_load(OP_LW, 32'h0000_3000, 32'hCAFE_F00D, TO - 1, 1'b0);
    check("last_ack_data", mem_data, 32'hCAFE_F00D);

    run_load(OP_LW,  32'h0000_4000, 32'hA5A5_5A5A, 0, 1'b1);
    run_load(OP_LBU, 32'h0000_4001, 32'h0102_0304, 1, 1'b1);
    run_load(OP_LH,  32'h0000_4002, 32'hFEDC_BA98, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1:    r_op = OP_LB;
        2:       r_op = OP_LBU;
        3, 4:    r_op = OP_LH;
        5:       r_op = OP_LHU;
        6, 7, 8: r_op = OP_LW;
        default: r_op = 6'($urandom);
      endcase
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (r_op == OP_LW)                        r_addr[1:0] = 2'b00;
        else if (r_op == OP_LH || r_op == OP_LHU) r_addr[0]   = 1'b0;
      end
      run_load(r_op, r_addr, $urandom, $urandom_range(0, TO + 1), 1'($urandom_range(0, 1)));
    end

    MemRead = 1'b0;
    @(posedge clock); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
